// File: rtl/enemy_wave_controller.sv
// enemy_wave_controller: formation controller for descending enemy sprites (clk25 pixel domain).
// Latency: wave_start, kill requests and movement ticks all take effect on the following cycle.
// Backpressure: none; every hit_valid strobe gets exactly one ack/nack pulse one cycle later.
//
// Ports:
//   clk25, reset_n         clock and asynchronous active-low reset
//   wave_start             one-cycle pulse, (re)loads the formation and enters RUN
//   speed                  descent step per movement tick is speed+1 pixels
//   hit_valid, hit_idx     kill request strobe and target enemy index
//   kill_ack, kill_nack    one-cycle response to each kill request
//   fly_x_flat, fly_y_flat packed positions, enemy i at [i*COORD_W +: COORD_W]
//   fly_alive_flat         alive mask
//   escaped, escape_count  escape pulse and saturating escape tally
//   wave_clear, busy       wave-cleared pulse and wave-in-progress flag
//
// Optional feature: define ZIGZAG_EN to add the horizontal zig-zag sweep.
module enemy_wave_controller #(
  parameter int N_ENEMY     = 17,
  parameter int COORD_W     = 10,
  parameter int X_STEP      = 38,
  parameter int Y_STAGGER   = 4,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_H    = 32,
  parameter int MOVE_PERIOD = 32768,
  parameter int ZIG_AMP     = 8
) (
  input  logic                         clk25,
  input  logic                         reset_n,
  input  logic                         wave_start,
  input  logic [1:0]                   speed,
  input  logic                         hit_valid,
  input  logic [4:0]                   hit_idx,
  output logic                         kill_ack,
  output logic                         kill_nack,
  output logic [COORD_W*N_ENEMY-1:0]   fly_x_flat,
  output logic [COORD_W*N_ENEMY-1:0]   fly_y_flat,
  output logic [N_ENEMY-1:0]           fly_alive_flat,
  output logic                         escaped,
  output logic [7:0]                   escape_count,
  output logic                         wave_clear,
  output logic                         busy
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [COORD_W-1:0] Y_LIMIT  = COORD_W'(SCREEN_H - SPRITE_H);

  // Elaboration-time parameter sanity checks.
  if (N_ENEMY < 2 || N_ENEMY > 32) begin : g_bad_n_enemy
    $error("enemy_wave_controller: N_ENEMY must be 2..32");
  end
  if (MOVE_PERIOD < 2) begin : g_bad_period
    $error("enemy_wave_controller: MOVE_PERIOD must be >= 2");
  end
  if (SCREEN_H - SPRITE_H + 3 >= (1 << COORD_W)) begin : g_bad_coord_w
    $error("enemy_wave_controller: COORD_W too narrow, y could wrap");
  end
  if (ZIG_AMP < 1 || ZIG_AMP >= (1 << COORD_W)) begin : g_bad_zig_amp
    $error("enemy_wave_controller: ZIG_AMP out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic [COORD_W-1:0] x_q [N_ENEMY];
  logic [COORD_W-1:0] y_q [N_ENEMY];
  logic [N_ENEMY-1:0] alive;

  logic               tick;
  logic               kill_ok;
  logic [N_ENEMY-1:0] hit_sel;
  logic [N_ENEMY-1:0] kill_vec;
  logic [N_ENEMY-1:0] escape_vec;
  logic [N_ENEMY-1:0] move_vec;
  logic [N_ENEMY-1:0] alive_nxt;
  logic [5:0]         escape_pop;
  logic [8:0]         escape_sum;
  logic [COORD_W-1:0] y_step;

  assign tick   = (state == S_RUN) && (tick_cnt == CNT_LAST);
  assign y_step = COORD_W'(speed) + COORD_W'(1);

  // A kill is resolved before the tick, so an enemy killed on its escape tick
  // is neither moved nor counted as escaped.
  always_comb begin
    hit_sel    = '0;
    kill_vec   = '0;
    escape_vec = '0;
    move_vec   = '0;
    escape_pop = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      hit_sel[i] = (hit_idx == 5'(i));
    end
    if (hit_valid && !wave_start && (state == S_RUN)) begin
      kill_vec = hit_sel & alive;
    end
    for (int i = 0; i < N_ENEMY; i++) begin
      if (tick && alive[i] && !kill_vec[i]) begin
        if (y_q[i] >= Y_LIMIT) begin
          escape_vec[i] = 1'b1;
        end else begin
          move_vec[i] = 1'b1;
        end
      end
      escape_pop = escape_pop + 6'(escape_vec[i]);
    end
    kill_ok    = |kill_vec;
    alive_nxt  = alive & ~kill_vec & ~escape_vec;
    escape_sum = {1'b0, escape_count} + 9'(escape_pop);
  end

`ifdef ZIGZAG_EN
  // Shared sweep offset: climbs to ZIG_AMP, falls back to 0, repeats.
  logic [COORD_W-1:0] zig_off;
  logic [COORD_W-1:0] zig_off_nxt;
  logic               zig_up;

  assign zig_off_nxt = zig_up ? (zig_off + COORD_W'(1)) : (zig_off - COORD_W'(1));

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      zig_off <= '0;
      zig_up  <= 1'b1;
    end else if (wave_start) begin
      zig_off <= '0;
      zig_up  <= 1'b1;
    end else if (tick) begin
      zig_off <= zig_off_nxt;
      if ((zig_off_nxt == COORD_W'(ZIG_AMP)) || (zig_off_nxt == '0)) begin
        zig_up <= ~zig_up;
      end
    end
  end
`else
  // Without the zig-zag sweep, x stays at its wave_start position.
`endif

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      alive        <= '0;
      kill_ack     <= 1'b0;
      kill_nack    <= 1'b0;
      escaped      <= 1'b0;
      escape_count <= '0;
      wave_clear   <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      kill_ack   <= hit_valid && kill_ok;
      kill_nack  <= hit_valid && !kill_ok;
      escaped    <= 1'b0;
      wave_clear <= 1'b0;

      if (wave_start) begin
        state        <= S_RUN;
        busy         <= 1'b1;
        tick_cnt     <= '0;
        alive        <= '1;
        escape_count <= '0;
        // Columns stagger downward toward the middle of the formation.
        for (int i = 0; i < N_ENEMY; i++) begin
          x_q[i] <= COORD_W'(i * X_STEP);
          y_q[i] <= COORD_W'(((i < N_ENEMY - 1 - i) ? i : (N_ENEMY - 1 - i)) * Y_STAGGER);
        end
      end else begin
        case (state)
          S_RUN: begin
            tick_cnt <= tick ? '0 : (tick_cnt + CNT_W'(1));
            alive    <= alive_nxt;
            for (int i = 0; i < N_ENEMY; i++) begin
              if (move_vec[i]) begin
                y_q[i] <= y_q[i] + y_step;
`ifdef ZIGZAG_EN
                x_q[i] <= zig_up ? (x_q[i] + COORD_W'(1)) : (x_q[i] - COORD_W'(1));
`endif
              end
            end
            if (|escape_vec) begin
              escaped      <= 1'b1;
              escape_count <= escape_sum[8] ? 8'hFF : escape_sum[7:0];
            end
            // busy stays up through the one-cycle CLEAR state.
            if (alive_nxt == '0) begin
              state      <= S_CLEAR;
              wave_clear <= 1'b1;
            end
          end
          S_CLEAR: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end
          default: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_flat
    assign fly_x_flat[g*COORD_W +: COORD_W] = x_q[g];
    assign fly_y_flat[g*COORD_W +: COORD_W] = y_q[g];
  end
  assign fly_alive_flat = alive;

endmodule
